if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  BITS  fetch address, equal to current PC.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid, exactly one cycle after grant.
REQ-009 SHALL have port imem_rdata  input  BITS  instruction word.
REQ-010 SHALL have port redirect  input  1  branch/jump taken, restart fetch.
REQ-011 SHALL have port redirect_pc  input  BITS  restart address.
REQ-012 SHALL have port id_ready  input  1  downstream IF/ID register can load.
REQ-013 SHALL have port if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-014 SHALL have port if_instr  output  BITS  instruction to IF/ID.
REQ-015 SHALL have port if_pc  output  BITS  address of if_instr, to IF/ID pc_addr.
REQ-016 SHALL have port perf_stall_cnt  output  16  stall counter (present only per REQ-036).

Function
REQ-017 SHALL hold PC register; imem_addr = PC; imem_req only asserted in state RUN.
REQ-018 SHALL implement states BOOT, RUN, HOLD: BOOT->RUN after one cycle; RUN->HOLD when credit = 0; HOLD->RUN when credit > 0; redirect from any state -> RUN.
REQ-019 SHALL compute credit = 2 - occupancy - outstanding + pop_this_cycle + rvalid_this_cycle; imem_req = RUN && credit > 0 && !redirect (combinational dependence on id_ready/imem_rvalid permitted).
REQ-020 SHALL allow at most one outstanding request; on imem_req && imem_gnt, PC <= PC + 4, wrapping modulo 2^BITS.
REQ-021 SHALL tag each granted request with its PC and the current epoch bit.
REQ-022 SHALL on imem_rvalid push {tagged PC, imem_rdata} into a 2-entry FIFO if tag epoch equals current epoch, else discard.
REQ-023 SHALL drive if_valid/if_instr/if_pc from FIFO head; pop when if_valid && id_ready; push and pop same cycle allowed at any occupancy.
REQ-024 SHALL never push into a full FIFO (guaranteed by credit); never drop an epoch-matching response.
REQ-025 SHALL keep if_instr/if_pc stable while if_valid && !id_ready.
REQ-026 SHALL on redirect: PC <= {redirect_pc[BITS-1:2], 2'b00}, flush FIFO, toggle epoch, suppress imem_req that cycle; if_valid = 0 next cycle.
REQ-027 SHALL give redirect priority over simultaneous grant, rvalid and pop; response in flight during redirect is discarded.
REQ-028 SHALL have latency: grant at cycle N, rvalid N+1, if_valid at N+2; sustained 1 instruction/cycle when imem_gnt and id_ready held high.
REQ-029 SHALL not accept imem_rvalid without outstanding request; such pulses ignored.

Reset
REQ-030 SHALL on rst_ low asynchronously set: state BOOT, PC = RESET_PC, FIFO empty, outstanding = 0, epoch = 0.
REQ-031 SHALL drive during reset: imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, perf_stall_cnt 0.
REQ-032 SHALL on reset mid-operation discard any in-flight response arriving after rst_ release.
REQ-033 SHALL release reset synchronously to clk internally; first imem_req one cycle after release.

Configuration
REQ-034 SHALL use macro IF_FETCH_PERF_EN.
REQ-035 SHALL without macro omit perf_stall_cnt port and all counter logic.
REQ-036 SHALL with macro provide perf_stall_cnt: increments each cycle with if_valid && !id_ready, saturates at 16'hFFFF, cleared only by reset.

Verification
REQ-037 SHALL test reset: RESET_PC=32'h100, gnt/id_ready=1 -> imem_addr 100,104,108 on consecutive cycles; if_pc 100 two cycles after first grant.
REQ-038 SHALL test backpressure: id_ready=0 four cycles -> FIFO fills to 2, imem_req deasserts, if_pc stable, no instruction lost or duplicated on release.
REQ-039 SHALL test redirect with response in flight: redirect_pc=32'h2003 -> old response discarded, next imem_addr 32'h2000, if_valid 0 next cycle.
REQ-040 SHALL test wrap: PC=32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000.
REQ-041 SHALL test gnt deasserted alternate cycles -> PC advances only on granted cycles, if_pc sequence contiguous.
REQ-042 SHALL test with IF_FETCH_PERF_EN: id_ready=0 for 10 cycles while if_valid=1 -> perf_stall_cnt = 10.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, single outstanding imem request, 2-entry response FIFO.
// Define IF_FETCH_PERF_EN to add the perf_stall_cnt backpressure counter.

module if_fetch #(
   parameter int unsigned     BITS     = 32,
   parameter logic [BITS-1:0] RESET_PC = BITS'(32'h0000_0000)
) (
   input  logic            clk,
   input  logic            rst_,
   output logic            imem_req,
   output logic [BITS-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [BITS-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [BITS-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [BITS-1:0] if_instr,
   output logic [BITS-1:0] if_pc
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [15:0]     perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e          state_q, state_d;
   logic [BITS-1:0] pc_q;
   logic [BITS-1:0] tag_pc_q;
   logic            out_q;
   logic            tag_epoch_q;
   logic            epoch_q;
   logic [BITS-1:0] fifo_pc_q    [2];
   logic [BITS-1:0] fifo_instr_q [2];
   logic            rd_ptr_q, wr_ptr_q;
   logic [1:0]      cnt_q;

   logic            rv_acc, push, pop, fire;
   logic [2:0]      credit;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign imem_addr = pc_q;
   assign if_valid  = (cnt_q != 2'd0);
   assign if_instr  = fifo_instr_q[rd_ptr_q];
   assign if_pc     = fifo_pc_q[rd_ptr_q];

   always_comb begin
      // rvalid with nothing outstanding (stray, or left over from before reset) is ignored
      rv_acc   = imem_rvalid & out_q;
      push     = rv_acc & (tag_epoch_q == epoch_q) & ~redirect;
      pop      = if_valid & id_ready & ~redirect;
      // An accepted response only moves from outstanding into the FIFO; just a discarded one
      // frees a slot, otherwise a full FIFO plus an in-flight request could overflow.
      credit   = 3'd2 - {1'b0, cnt_q} - {2'b00, out_q} + {2'b00, pop}
                 + {2'b00, rv_acc & ~push};
      imem_req = (state_q == StRun) & (credit != 3'd0) & ~redirect;
      fire     = imem_req & imem_gnt;

      state_d = state_q;
      if (redirect) begin
         state_d = StRun;
      end else begin
         case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (credit == 3'd0) state_d = StHold;
            StHold:  if (credit != 3'd0) state_d = StRun;
            default: state_d = StBoot;
         endcase
      end
   end

   // StBoot absorbs reset release: nothing leaves its reset value before the first clk edge
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         out_q       <= 1'b0;
         tag_pc_q    <= '0;
         tag_epoch_q <= 1'b0;
         epoch_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (redirect) begin
            pc_q    <= {redirect_pc[BITS-1:2], 2'b00};
            epoch_q <= ~epoch_q;
         end else if (fire) begin
            pc_q <= pc_q + BITS'(4);
         end
         if (fire) begin
            out_q       <= 1'b1;
            tag_pc_q    <= pc_q;
            tag_epoch_q <= epoch_q;
         end else if (rv_acc) begin
            out_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
      end else if (redirect) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            fifo_pc_q[wr_ptr_q]    <= tag_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            wr_ptr_q               <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef IF_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         perf_stall_cnt <= 16'd0;
      end else if (if_valid && !id_ready && (perf_stall_cnt != 16'hFFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, backpressure, redirect, wrap, sparse grants.
// With IF_FETCH_PERF_EN defined the stall counter is checked as well.

module tb_if_fetch;

   logic        clk, rst_;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect, id_ready, if_valid;
   logic [31:0] redirect_pc, if_instr, if_pc;
`ifdef IF_FETCH_PERF_EN
   logic [15:0] perf_stall_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   if_fetch #(
      .BITS     (32),
      .RESET_PC (32'h0000_0100)
   ) u_dut (
      .clk         (clk),
      .rst_        (rst_),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // Advance one cycle; the memory answers the previous cycle's grant, then new inputs apply
   task automatic drive(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
      logic        f;
      logic [31:0] a;
      f = imem_req & imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = f;
      imem_rdata  = f ? mem_word(a) : 32'h0BAD_0BAD;
      imem_gnt    = g;
      id_ready    = r;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
   endtask

   initial begin
      rst_        = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b0;

      #12;
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_addr", imem_addr, 32'h100);
      check_eq("rst_valid", if_valid, 0);
      check_eq("rst_instr", if_instr, 0);
      check_eq("rst_pc", if_pc, 0);
`ifdef IF_FETCH_PERF_EN
      check_eq("rst_perf", perf_stall_cnt, 0);
`endif

      @(posedge clk);
      #1;
      rst_     = 1'b1;
      imem_gnt = 1'b1;
      id_ready = 1'b1;
      #1;
      check_eq("boot_req", imem_req, 0);

      // streaming
      drive(1, 1, 0, 0);
      check_eq("c1_req", imem_req, 1);
      check_eq("c1_addr", imem_addr, 32'h100);
      drive(1, 1, 0, 0);
      check_eq("c2_addr", imem_addr, 32'h104);
      check_eq("c2_valid", if_valid, 0);
      drive(1, 1, 0, 0);
      check_eq("c3_addr", imem_addr, 32'h108);
      check_eq("c3_valid", if_valid, 1);
      check_eq("c3_pc", if_pc, 32'h100);
      check_eq("c3_instr", if_instr, mem_word(32'h100));

      // backpressure: id_ready low for four cycles
      drive(1, 0, 0, 0);
      check_eq("c4_pc", if_pc, 32'h104);
      check_eq("c4_req", imem_req, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0);
         check_eq("bp_req", imem_req, 0);
         check_eq("bp_pc", if_pc, 32'h104);
         check_eq("bp_instr", if_instr, mem_word(32'h104));
      end
      drive(1, 1, 0, 0);
      check_eq("c8_pc", if_pc, 32'h104);
      check_eq("c8_req", imem_req, 0);
`ifdef IF_FETCH_PERF_EN
      check_eq("c8_perf", perf_stall_cnt, 4);
`endif
      drive(1, 1, 0, 0);
      check_eq("c9_pc", if_pc, 32'h108);
      check_eq("c9_addr", imem_addr, 32'h10C);
      check_eq("c9_req", imem_req, 1);
      drive(1, 1, 0, 0);
      check_eq("c10_valid", if_valid, 0);
      check_eq("c10_addr", imem_addr, 32'h110);
      drive(1, 1, 0, 0);
      check_eq("c11_pc", if_pc, 32'h10C);
      check_eq("c11_instr", if_instr, mem_word(32'h10C));

      // redirect while the 0x114 response is arriving
      drive(1, 1, 1, 32'h2003);
      check_eq("redir_req", imem_req, 0);
      drive(1, 1, 0, 0);
      check_eq("redir_valid", if_valid, 0);
      check_eq("redir_req1", imem_req, 1);
      check_eq("redir_addr", imem_addr, 32'h2000);
      drive(1, 1, 0, 0);
      check_eq("redir_addr1", imem_addr, 32'h2004);
      check_eq("redir_valid1", if_valid, 0);
      drive(1, 1, 0, 0);
      check_eq("redir_pc", if_pc, 32'h2000);
      check_eq("redir_instr", if_instr, mem_word(32'h2000));

      // PC wrap
      drive(1, 1, 1, 32'hFFFF_FFFF);
      check_eq("wrap_req0", imem_req, 0);
      drive(1, 1, 0, 0);
      check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      check_eq("wrap_valid", if_valid, 0);
      drive(1, 1, 0, 0);
      check_eq("wrap_addr1", imem_addr, 32'h0000_0000);
      drive(1, 1, 0, 0);
      check_eq("wrap_pc0", if_pc, 32'hFFFF_FFFC);
      drive(1, 1, 0, 0);
      check_eq("wrap_pc1", if_pc, 32'h0000_0000);

      // grant on alternate cycles
      drive(1, 1, 1, 32'h3000);
      drive(0, 1, 0, 0);
      check_eq("alt_addr0", imem_addr, 32'h3000);
      check_eq("alt_req0", imem_req, 1);
      drive(1, 1, 0, 0);
      check_eq("alt_addr1", imem_addr, 32'h3000);
      drive(0, 1, 0, 0);
      check_eq("alt_addr2", imem_addr, 32'h3004);
      check_eq("alt_valid2", if_valid, 0);
      drive(1, 1, 0, 0);
      check_eq("alt_addr3", imem_addr, 32'h3004);
      check_eq("alt_pc3", if_pc, 32'h3000);
      drive(0, 1, 0, 0);
      check_eq("alt_addr4", imem_addr, 32'h3008);
      check_eq("alt_valid4", if_valid, 0);
      drive(1, 1, 0, 0);
      check_eq("alt_pc5", if_pc, 32'h3004);

      // reset mid-operation, then a late response arrives right after release
      rst_ = 1'b0;
      #1;
      check_eq("mrst_req", imem_req, 0);
      check_eq("mrst_addr", imem_addr, 32'h100);
      check_eq("mrst_valid", if_valid, 0);
      check_eq("mrst_pc", if_pc, 0);
`ifdef IF_FETCH_PERF_EN
      check_eq("mrst_perf", perf_stall_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst_        = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(32'h3008);
      imem_gnt    = 1'b1;
      id_ready    = 1'b1;
      redirect    = 1'b0;
      #1;
      check_eq("stray_valid", if_valid, 0);
      check_eq("stray_req", imem_req, 0);
      drive(1, 1, 0, 0);
      check_eq("r1_valid", if_valid, 0);
      check_eq("r1_addr", imem_addr, 32'h100);
      check_eq("r1_req", imem_req, 1);
      drive(1, 1, 0, 0);
      check_eq("r2_valid", if_valid, 0);

      // ten stall cycles with a valid instruction at the head
      drive(1, 0, 0, 0);
      check_eq("r3_pc", if_pc, 32'h100);
`ifdef IF_FETCH_PERF_EN
      check_eq("r3_perf", perf_stall_cnt, 0);
`endif
      for (int i = 0; i < 9; i++) drive(1, 0, 0, 0);
      check_eq("r12_pc", if_pc, 32'h100);
      check_eq("r12_req", imem_req, 0);
      drive(1, 1, 0, 0);
      check_eq("r13_pc", if_pc, 32'h100);
`ifdef IF_FETCH_PERF_EN
      check_eq("r13_perf", perf_stall_cnt, 10);
`endif
      drive(1, 1, 0, 0);
      check_eq("r14_pc", if_pc, 32'h104);
      check_eq("r14_instr", if_instr, mem_word(32'h104));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
